// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single main-memory port (I-cache refill on port 0,
// D-cache refill/write-through on port 1) with round-robin or fixed priority and a watchdog.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TIMEOUT    = 255,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ready,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ready,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              grant,
  output logic              timeout_err
);

  localparam int unsigned     WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state;
  logic            last_grant;
  logic [WD_W-1:0] watchdog;
  logic [WD_W-1:0] watchdog_next;
  logic            winner;

  // On a conflict, round-robin favours the port that did not win last time.
  always_comb begin
    winner = 1'b0;
    if (p0_req && p1_req)
      winner = FIXED_PRIO ? 1'b0 : !last_grant;
    else
      winner = !p0_req;
    watchdog_next = watchdog + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      watchdog     <= '0;
      grant        <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
      p0_ready     <= 1'b0;
      p1_ready     <= 1'b0;
    end else begin
      p0_ready <= 1'b0;
      p1_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            grant        <= winner;
            last_grant   <= winner;
            mem_addr     <= winner ? p1_addr  : p0_addr;
            mem_wdata    <= winner ? p1_wdata : p0_wdata;
            mem_read_en  <= winner ? !p1_we   : !p0_we;
            mem_write_en <= winner ? p1_we    : p0_we;
            watchdog     <= '0;
            busy         <= 1'b1;
            state        <= BUSY;
          end
        end
        BUSY: begin
          watchdog <= watchdog_next;
          if (mem_ready || watchdog_next == WD_MAX) begin
            if (mem_ready && mem_read_en) begin
              if (grant) p1_rdata <= mem_rdata;
              else       p0_rdata <= mem_rdata;
            end
            if (!mem_ready) timeout_err <= 1'b1;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            p0_ready     <= !grant;
            p1_ready     <= grant;
            state        <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
